fnd_scan_driver: RTL and testbench
==================================

Name: fnd_scan_driver

Overview:
- Consumes the ~1 kHz divided FND clock (50 % duty, generated on the same system clock) and drives a 4-digit common-anode 7-segment display.
- Captures a binary value once per scan frame and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the four digits with optional leading-zero blanking and per-digit decimal points.
- Sits directly downstream of the FND clock divider and directly upstream of the board FND pins.

Parameters:
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all four digits.
- VALUE_MAX, 9999, saturation limit applied to the captured value.

Ports:
- i_clk  input  1  system clock (100 MHz).
- i_reset  input  1  synchronous, active-high reset.
- i_fnd_clk  input  1  divided scan clock from the divider; sampled as data, synchronous to i_clk.
- i_value  input  14  unsigned binary value to display.
- i_dp  input  4  decimal-point enables; bit k belongs to digit k, active-high.
- o_fnd_com  output  4  digit select, active-low; bit 0 = ones digit.
- o_fnd_font  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_busy  output  1  high while BCD conversion is running.

Behaviour:
- Clock and reset: single clock domain, posedge i_clk; reset is synchronous and active-high.
- Reset values:
  - o_fnd_com = 4'b1111, o_fnd_font = 8'hFF, o_busy = 0.
  - Digit index = 3, edge-detect flop = 0, BCD display register = 16'h0000, conversion FSM = IDLE.
- Scan tick: tick = i_fnd_clk & ~r_fnd_clk_d, where r_fnd_clk_d is i_fnd_clk delayed one i_clk cycle. There is one tick per i_fnd_clk rising edge.
- On the clock edge in which tick is high:
  - Digit index advances 0→1→2→3→0.
  - o_fnd_com and o_fnd_font update together to the new digit. Latency is 1 cycle from i_fnd_clk first sampled high.
- Without ticks, outputs hold. Until the first tick after reset, the display stays dark.
- o_fnd_com is one-hot-low: digit k gives ~(1<<k).
- Font map: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
  - Bit 7 is cleared when i_dp[k]=1, including on blanked digits.
  - BCD nibble codes 10–15 cannot occur and map to blank.
- Leading-zero blanking (LZ_BLANK=1): digit k>0 is blank when BCD digits k..3 are all zero.
- Frame start: a tick that moves index 3→0 also does the following:
  - Captures min(i_value, VALUE_MAX) into the shift register.
  - Starts conversion: FSM goes IDLE→SHIFT, and o_busy goes 1 on the next edge.
- SHIFT state:
  - 14 iterations, one per clock. Each iteration adds 3 to every BCD nibble ≥5, then shifts left 1.
  - After the 14th iteration the FSM goes to DONE, the BCD result is committed to the display register, and the FSM returns to IDLE with o_busy = 0.
  - o_busy is high for exactly 14 cycles.
- Update timing: the digit shown on the frame-start tick uses the old display register. New values appear from the tick into digit 1 of the same frame onward, because ticks are far slower than conversion.
- A frame-start tick arriving while busy (only possible if the bench drives i_fnd_clk fast) is ignored for capture. The conversion in progress completes, and scanning still advances.
- i_value changes mid-frame are invisible until the next frame start.
- A reset asserted mid-conversion aborts it. The display register reverts to 0 and outputs go dark on the next edge.
- i_fnd_clk held high produces no further ticks.

Test Plan:
- Reset, then 4 ticks with i_value=0 and i_dp=0 → com 1110/1101/1011/0111 in turn; font C0, then FF, FF, FF (LZ_BLANK=1).
- i_value=1234, two full frames → second frame shows digit0=99, digit1=B0, digit2=A4, digit3=F9. o_busy is high for exactly 14 cycles after each 3→0 tick.
- i_value=16383 → display 9999; every digit shows font 90.
- i_value=5, i_dp=4'b0100 → digit0=92, digit1=FF, digit2=7F, digit3=FF. With LZ_BLANK=0: digit1=C0, digit2=40, digit3=C0.
- i_value=0→4321 changed during digit 2 of a frame → current frame keeps showing the old value; 4321 appears only after the next frame-start tick.
- i_reset pulsed 5 cycles into conversion → o_busy=0, com=1111, font=FF on the next edge; the first post-reset frame shows 0.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode FND scanner with a sequential double-dabble
// converter that refreshes the displayed value once per scan frame.
module fnd_scan_driver #(
   parameter bit LZ_BLANK  = 1'b1,
   parameter int VALUE_MAX = 9999
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_fnd_clk,
   input  logic [13:0] i_value,
   input  logic [3:0]  i_dp,
   output logic [3:0]  o_fnd_com,
   output logic [7:0]  o_fnd_font,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [13:0] VMAX = 14'(VALUE_MAX);

   state_t      state, state_nxt;
   logic        fnd_clk_d;
   logic        tick;
   logic        frame_start;
   logic [1:0]  idx, idx_nxt;
   logic [13:0] bin;
   logic [15:0] bcd, bcd_adj;
   logic [15:0] disp;
   logic [3:0]  cnt;
   logic        load, step, commit;
   logic [3:0]  dig;
   logic        blank;
   logic [7:0]  seg;
   logic [7:0]  font_nxt;

   assign tick        = i_fnd_clk & ~fnd_clk_d;
   assign idx_nxt     = idx + 2'd1;
   assign frame_start = tick && (idx == 2'd3);
   assign o_busy      = (state == SHIFT);

   // Conversion FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state and datapath strobes; a frame start while busy is ignored.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == 4'd13) state_nxt = DONE;
         end
         DONE: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction on every BCD nibble of 5 or more.
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < 4; k++) begin
         if (bcd[k*4 +: 4] >= 4'd5)
            bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
      end
   end

   // Double-dabble shift registers and display commit.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bin  <= '0;
         bcd  <= '0;
         cnt  <= '0;
         disp <= '0;
      end else begin
         if (load) begin
            bin <= (i_value > VMAX) ? VMAX : i_value;
            bcd <= '0;
            cnt <= '0;
         end else if (step) begin
            bcd <= {bcd_adj[14:0], bin[13]};
            bin <= {bin[12:0], 1'b0};
            cnt <= cnt + 4'd1;
         end
         if (commit) disp <= bcd;
      end
   end

   // Leading-zero blanking and font lookup for the next digit.
   always_comb begin
      dig   = disp[{idx_nxt, 2'b00} +: 4];
      blank = 1'b0;
      case (idx_nxt)
         2'd1:    blank = LZ_BLANK && (disp[15:4] == 12'd0);
         2'd2:    blank = LZ_BLANK && (disp[15:8] == 8'd0);
         2'd3:    blank = LZ_BLANK && (disp[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
      case (dig)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = 8'hFF;
      endcase
      if (blank) seg = 8'hFF;
      font_nxt = seg & {~i_dp[idx_nxt], 7'h7F};
   end

   // Scan edge detect, digit index and registered pin outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fnd_clk_d  <= 1'b0;
         idx        <= 2'd3;
         o_fnd_com  <= 4'b1111;
         o_fnd_font <= 8'hFF;
      end else begin
         fnd_clk_d <= i_fnd_clk;
         if (tick) begin
            idx        <= idx_nxt;
            o_fnd_com  <= ~(4'b0001 << idx_nxt);
            o_fnd_font <= font_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver; a second instance runs with
// leading-zero blanking disabled.
module tb_fnd_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        fnd;
   logic [13:0] value;
   logic [3:0]  dp;
   logic [3:0]  com, com0;
   logic [7:0]  font, font0;
   logic        busy, busy0;

   int n_cmp = 0;
   int n_err = 0;
   int m_idx;
   int m_disp;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   fnd_scan_driver #(.LZ_BLANK(1'b1), .VALUE_MAX(9999)) dut (
      .i_clk(clk), .i_reset(reset), .i_fnd_clk(fnd), .i_value(value),
      .i_dp(dp), .o_fnd_com(com), .o_fnd_font(font), .o_busy(busy));

   fnd_scan_driver #(.LZ_BLANK(1'b0), .VALUE_MAX(9999)) dut0 (
      .i_clk(clk), .i_reset(reset), .i_fnd_clk(fnd), .i_value(value),
      .i_dp(dp), .o_fnd_com(com0), .o_fnd_font(font0), .o_busy(busy0));

   function automatic logic [7:0] exp_font(int v, int k, bit lz,
                                           logic [3:0] p);
      logic [7:0] tbl [10];
      logic [7:0] f;
      int d, hi;
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      hi = v;
      for (int i = 0; i < k; i++) hi = hi / 10;
      d = hi % 10;
      if (lz && k > 0 && hi == 0) f = 8'hFF;
      else f = tbl[d];
      if (p[k]) f[7] = 1'b0;
      return f;
   endfunction

   task automatic do_tick(input bit wait_conv);
      int nidx, bc;
      bit fs;
      logic [3:0] ec;
      logic [23:0] e, got;
      @(posedge clk); #1;
      fnd = 1'b1;
      nidx = (m_idx + 1) % 4;
      ec = ~(4'b0001 << nidx);
      sb.push_back({ec, exp_font(m_disp, nidx, 1'b1, dp),
                    ec, exp_font(m_disp, nidx, 1'b0, dp)});
      fs = (nidx == 0);
      m_idx = nidx;
      if (fs) m_disp = (int'(value) > 9999) ? 9999 : int'(value);
      @(posedge clk); #1;
      got = {com, font, com0, font0};
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL tick_scoreboard_empty got=%h", got);
         e = got;
      end else begin
         e = sb.pop_front();
         if (got !== e) begin
            n_err++;
            $display("FAIL tick_digit%0d got=%h exp=%h", nidx, got, e);
         end
      end
      if (fs) begin
         n_cmp++;
         if (busy !== 1'b1 || busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_start got=%b/%b exp=1", busy, busy0);
         end
      end
      if (!wait_conv) return;
      if (fs) begin
         bc = 0;
         for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            else break;
            @(posedge clk); #1;
         end
         n_cmp++;
         if (bc !== 14) begin
            n_err++;
            $display("FAIL busy_len got=%0d exp=14", bc);
         end
      end else begin
         repeat (3) begin @(posedge clk); #1; end
      end
      got = {com, font, com0, font0};
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL hold_digit%0d got=%h exp=%h", nidx, got, e);
      end
      fnd = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      fnd   = 1'b0;
      value = '0;
      dp    = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({com, font, busy, com0, font0} !== {4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF}) begin
         n_err++;
         $display("FAIL reset_state got=%h %h %b", com, font, busy);
      end
      reset = 1'b0;
      m_idx = 3;
      m_disp = 0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if ({com, font} !== {4'hF, 8'hFF}) begin
         n_err++;
         $display("FAIL dark_before_tick got=%h %h exp=f ff", com, font);
      end
   endtask

   task automatic test_zero();
      value = 14'd0;
      dp = 4'b0000;
      repeat (4) do_tick(1'b1);
   endtask

   task automatic test_value(input int v, input logic [3:0] p);
      value = 14'(v);
      dp = p;
      repeat (8) do_tick(1'b1);
   endtask

   task automatic test_midframe();
      value = 14'd0;
      dp = 4'b0000;
      while (m_idx != 3) do_tick(1'b1);
      do_tick(1'b1);
      do_tick(1'b1);
      do_tick(1'b1);
      value = 14'd4321;
      repeat (5) do_tick(1'b1);
   endtask

   task automatic test_reset_mid();
      value = 14'd9876;
      dp = 4'b0000;
      while (m_idx != 3) do_tick(1'b1);
      do_tick(1'b0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      fnd = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, com, font, com0, font0} !== {1'b0, 4'hF, 8'hFF, 4'hF, 8'hFF}) begin
         n_err++;
         $display("FAIL reset_mid got=%b %h %h", busy, com, font);
      end
      reset = 1'b0;
      m_idx = 3;
      m_disp = 0;
      repeat (2) @(posedge clk);
      value = 14'd7777;
      repeat (8) do_tick(1'b1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_zero();
      test_value(1234, 4'b0000);
      test_value(16383, 4'b0000);
      test_value(5, 4'b0100);
      test_value(9999, 4'b1001);
      test_value(10000, 4'b0000);
      test_value(60, 4'b0000);
      test_midframe();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
